alu_arbiter: RTL

Two-port round-robin arbiter and scheduler that shares one clocked 8-bit ALU between two requesters. Each requester presents an opcode and two operands under a valid/ready handshake. The block registers the winning operation onto the ALU input ports and tracks in-flight operations in a tag pipeline. It routes each ALU result back to the requester that issued it as a one-cycle response pulse. It sits between the ALU and its clients (sequencer, test harness) and permits one new operation per clock.

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter/scheduler sharing one clocked 8-bit ALU; tags route results back.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
module alu_arbiter #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_opcode0,
  input  logic [3:0] req_opcode1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_b1,
  output logic [1:0] resp_valid,
  output logic [7:0] resp_data,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  output logic       busy
);

  localparam int unsigned DEPTH = ALU_LATENCY + 1;

  logic [1:0]       grant;
  logic             accept;
  logic             win_id;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [DEPTH-1:0] tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0] tag_id_q, tag_id_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    grant[0] = req_valid[0];
    grant[1] = req_valid[1] & ~req_valid[0];
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Pointer always lands on the requester that lost (or was absent) this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = ~win_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign req_ready = grant;
  assign accept    = |grant;
  assign win_id    = grant[1];

  always_comb begin
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    if (accept) begin
      alu_opcode_d = win_id ? req_opcode1 : req_opcode0;
      alu_a_d      = win_id ? req_a1 : req_a0;
      alu_b_d      = win_id ? req_b1 : req_b0;
    end
  end

  // Entry 0 is the newest issue; entry DEPTH-1 lines up with the ALU result.
  always_comb begin
    tag_vld_d = {tag_vld_q[DEPTH-2:0], accept};
    tag_id_d  = {tag_id_q[DEPTH-2:0], accept & win_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (tag_vld_q[DEPTH-1]) begin
      resp_valid = tag_id_q[DEPTH-1] ? 2'b10 : 2'b01;
      resp_data  = alu_out;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign busy       = |tag_vld_q;

endmodule
